// File: rtl/phys_reg_file_mp_if.sv
// phys_reg_file_mp_if
//   Bundle of the register-file buses: writeback ports, rename allocation
//   ports, operand read ports and the sticky write-collision flag.
//   master : driven by rename/issue/writeback (writes, allocs, read indices)
//   slave  : the register file (returns read data, ready flags, conflict)
interface phys_reg_file_mp_if #(
    parameter int NUM_PREGS = 128,
    parameter int XLEN      = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int PW        = $clog2(NUM_PREGS)
);
    logic [NUM_WR-1:0]         wr_en;
    logic [NUM_WR*PW-1:0]      wr_pd;
    logic [NUM_WR*XLEN-1:0]    wr_data;
    logic [NUM_ALLOC-1:0]      alloc_en;
    logic [NUM_ALLOC*PW-1:0]   alloc_pd;
    logic [NUM_RD*PW-1:0]      rd_ps;
    logic [NUM_RD*XLEN-1:0]    rd_data;
    logic [NUM_RD-1:0]         rd_rdy;
    logic                      wr_conflict;

    modport master (
        output wr_en, wr_pd, wr_data, alloc_en, alloc_pd, rd_ps,
        input  rd_data, rd_rdy, wr_conflict
    );

    modport slave (
        input  wr_en, wr_pd, wr_data, alloc_en, alloc_pd, rd_ps,
        output rd_data, rd_rdy, wr_conflict
    );
endinterface

// File: rtl/phys_reg_file_mp.sv
// phys_reg_file_mp
//   Multi-ported physical register file with per-register ready scoreboard
//   and same-cycle write-to-read bypass of data and ready.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : phys_reg_file_mp_if.slave
//           wr_en/wr_pd/wr_data     NUM_WR writeback ports (sets ready)
//           alloc_en/alloc_pd       NUM_ALLOC rename allocations (clears ready)
//           rd_ps -> rd_data/rd_rdy NUM_RD combinational read ports
//           wr_conflict             sticky: two writes hit the same nonzero PD
//   p0 is hardwired to value 0, ready 1.
module phys_reg_file_mp #(
    parameter int NUM_PREGS = 128,
    parameter int XLEN      = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int ARCH_REGS = 32,
    parameter int PW        = $clog2(NUM_PREGS)
) (
    input logic               clk,
    input logic               reset,
    phys_reg_file_mp_if.slave bus
);

    logic [XLEN-1:0]      regs [NUM_PREGS];
    logic [NUM_PREGS-1:0] rdy_q;
    logic                 conflict_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                regs[i] <= (i < ARCH_REGS) ? XLEN'(i) : '0;
            end
            rdy_q      <= '1;
            conflict_q <= 1'b0;
        end else begin
            // Ascending port order: the highest-index port's NBA lands last
            // and therefore wins a data collision.
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && bus.wr_pd[w*PW +: PW] != '0) begin
                    regs[bus.wr_pd[w*PW +: PW]]  <= bus.wr_data[w*XLEN +: XLEN];
                    rdy_q[bus.wr_pd[w*PW +: PW]] <= 1'b1;
                end
            end
            // Allocation clears come after writes so they override the
            // writeback ready-set on the same index.
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (bus.alloc_en[a] && bus.alloc_pd[a*PW +: PW] != '0) begin
                    rdy_q[bus.alloc_pd[a*PW +: PW]] <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_WR; i++) begin
                for (int j = i + 1; j < NUM_WR; j++) begin
                    if (bus.wr_en[i] && bus.wr_en[j] &&
                        bus.wr_pd[i*PW +: PW] == bus.wr_pd[j*PW +: PW] &&
                        bus.wr_pd[i*PW +: PW] != '0) begin
                        conflict_q <= 1'b1;
                    end
                end
            end
        end
    end

    logic [NUM_RD*XLEN-1:0] rd_data_c;
    logic [NUM_RD-1:0]      rd_rdy_c;
    logic [PW-1:0]          ps;
    logic [XLEN-1:0]        d;
    logic                   k;

    always_comb begin
        rd_data_c = '0;
        rd_rdy_c  = '0;
        ps        = '0;
        d         = '0;
        k         = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            ps = bus.rd_ps[r*PW +: PW];
            d  = regs[ps];
            k  = rdy_q[ps];
            // Same priority as the array update: last matching port wins.
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && bus.wr_pd[w*PW +: PW] == ps) begin
                    d = bus.wr_data[w*XLEN +: XLEN];
                    k = 1'b1;
                end
            end
            if (ps == '0) begin
                d = '0;
                k = 1'b1;
            end
            rd_data_c[r*XLEN +: XLEN] = d;
            rd_rdy_c[r]               = k;
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_rdy      = rd_rdy_c;
    assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
module tb_phys_reg_file_mp;
    localparam int NUM_PREGS = 128;
    localparam int XLEN      = 32;
    localparam int NUM_RD    = 4;
    localparam int NUM_WR    = 2;
    localparam int NUM_ALLOC = 2;
    localparam int ARCH_REGS = 32;
    localparam int PW        = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    phys_reg_file_mp_if #(
        .NUM_PREGS(NUM_PREGS), .XLEN(XLEN), .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC), .PW(PW)
    ) bus ();

    phys_reg_file_mp #(
        .NUM_PREGS(NUM_PREGS), .XLEN(XLEN), .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC), .ARCH_REGS(ARCH_REGS), .PW(PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string       name;
        int          kind;   // 0: read port data+rdy, 1: wr_conflict
        int          port;
        logic [31:0] data;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Monitor: expectations for the current cycle are consumed at the
    // falling edge, well away from the rising edge where inputs change.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.kind == 0) begin
                n_checks++;
                if (bus.rd_data[e.port*XLEN +: XLEN] === e.data) n_pass++;
                else $display("FAIL %s data: got %h expected %h", e.name,
                              bus.rd_data[e.port*XLEN +: XLEN], e.data);
                n_checks++;
                if (bus.rd_rdy[e.port] === e.rdy) n_pass++;
                else $display("FAIL %s rdy: got %b expected %b", e.name,
                              bus.rd_rdy[e.port], e.rdy);
            end else begin
                n_checks++;
                if (bus.wr_conflict === e.rdy) n_pass++;
                else $display("FAIL %s wr_conflict: got %b expected %b", e.name,
                              bus.wr_conflict, e.rdy);
            end
        end
    end

    task automatic exp_rd(input string name, input int port, input int idx,
                          input logic [31:0] data, input logic rdy);
        exp_t e;
        bus.rd_ps[port*PW +: PW] = PW'(idx);
        e.name = name; e.kind = 0; e.port = port; e.data = data; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    task automatic exp_conf(input string name, input logic v);
        exp_t e;
        e.name = name; e.kind = 1; e.port = 0; e.data = '0; e.rdy = v;
        exp_q.push_back(e);
    endtask

    task automatic wr(input int port, input int idx, input logic [31:0] data);
        bus.wr_en[port]                 = 1'b1;
        bus.wr_pd[port*PW +: PW]        = PW'(idx);
        bus.wr_data[port*XLEN +: XLEN]  = data;
    endtask

    task automatic alloc(input int port, input int idx);
        bus.alloc_en[port]          = 1'b1;
        bus.alloc_pd[port*PW +: PW] = PW'(idx);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        bus.wr_en    = '0;
        bus.alloc_en = '0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.wr_en    = '0;
        bus.wr_pd    = '0;
        bus.wr_data  = '0;
        bus.alloc_en = '0;
        bus.alloc_pd = '0;
        bus.rd_ps    = '0;
        step();
        step();
        reset = 1'b1;

        exp_rd("rst_p5", 0, 5, 32'd5, 1'b1);
        exp_rd("rst_p40", 1, 40, 32'd0, 1'b1);
        exp_rd("rst_p0", 2, 0, 32'd0, 1'b1);
        exp_rd("rst_p31", 3, 31, 32'd31, 1'b1);
        exp_conf("rst_conf", 1'b0);
        step();

        alloc(0, 40);
        exp_rd("alloc_same_cycle", 0, 40, 32'd0, 1'b1);
        step();
        exp_rd("alloc_next", 0, 40, 32'd0, 1'b0);
        step();
        wr(1, 40, 32'hDEADBEEF);
        exp_rd("bypass_p40", 0, 40, 32'hDEADBEEF, 1'b1);
        exp_rd("bypass_other", 1, 41, 32'd0, 1'b1);
        step();
        exp_rd("array_p40", 0, 40, 32'hDEADBEEF, 1'b1);
        step();

        wr(0, 70, 32'h11);
        wr(1, 70, 32'h22);
        exp_rd("coll_bypass", 2, 70, 32'h22, 1'b1);
        exp_conf("coll_conf_same", 1'b0);
        step();
        exp_rd("coll_array", 2, 70, 32'h22, 1'b1);
        exp_conf("coll_conf_next", 1'b1);
        step();
        step();
        exp_conf("coll_conf_sticky", 1'b1);
        step();

        alloc(1, 90);
        wr(0, 90, 32'h55);
        exp_rd("aw_same", 3, 90, 32'h55, 1'b1);
        step();
        exp_rd("aw_next", 3, 90, 32'h55, 1'b0);
        step();

        wr(0, 0, 32'hFFFF);
        alloc(0, 0);
        exp_rd("p0_same", 1, 0, 32'd0, 1'b1);
        step();
        exp_rd("p0_next", 1, 0, 32'd0, 1'b1);
        step();

        wr(0, 33, 32'h1234);
        alloc(1, 40);
        step();
        exp_rd("pre_rst_p33", 0, 33, 32'h1234, 1'b1);
        exp_rd("pre_rst_p40", 1, 40, 32'hDEADBEEF, 1'b0);
        step();
        reset = 1'b0;
        wr(0, 33, 32'h9);
        exp_rd("in_rst_bypass", 0, 33, 32'h9, 1'b1);
        exp_rd("in_rst_p40", 1, 40, 32'hDEADBEEF, 1'b0);
        step();
        reset = 1'b1;
        exp_rd("post_rst_p33", 0, 33, 32'd0, 1'b1);
        exp_rd("post_rst_p40", 1, 40, 32'd0, 1'b1);
        exp_rd("post_rst_p5", 2, 5, 32'd5, 1'b1);
        exp_rd("post_rst_p70", 3, 70, 32'd0, 1'b1);
        exp_conf("post_rst_conf", 1'b0);
        step();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/phys_reg_file_mp.md
# phys_reg_file_mp

Multi-ported, parametrised physical register file for the renamed out-of-order pipeline, replacing the single-write, dual-read physical register file. It adds three things over that block:
- N read ports and M write ports.
- A per-register ready scoreboard, cleared on rename allocation and set on writeback.
- Same-cycle write-to-read bypass of both data and ready status.

It sits between rename/issue (allocation, operand reads) and the writeback buses.

## Interface
Parameters:
- NUM_PREGS, 128: physical register count; power of two, ≥ ARCH_REGS.
- XLEN, 32: data width.
- NUM_RD, 4: read ports.
- NUM_WR, 2: write ports.
- NUM_ALLOC, 2: allocation (ready-clear) ports.
- ARCH_REGS, 32: registers identity-initialised at reset.
- PW, $clog2(NUM_PREGS): physical index width (derived).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_pd  in  NUM_WR*PW  per-port destination index.
- wr_data  in  NUM_WR*XLEN  per-port write data.
- alloc_en  in  NUM_ALLOC  per-port allocation strobe.
- alloc_pd  in  NUM_ALLOC*PW  per-port register being allocated; its ready bit is cleared.
- rd_ps  in  NUM_RD*PW  per-port source index.
- rd_data  out  NUM_RD*XLEN  combinational read data.
- rd_rdy  out  NUM_RD  combinational operand-ready flag.
- wr_conflict  out  1  registered sticky flag: two write ports hit the same nonzero PD in the same cycle.

## Operation
Storage:
- regs[NUM_PREGS] × XLEN plus rdy[NUM_PREGS] × 1.
- p0 is hardwired: regs[0] reads 0 and rdy[0] reads 1. Writes and allocations to index 0 are ignored.

Reset (reset==0 at a clk edge):
- regs[i]=i for i<ARCH_REGS; regs[i]=0 otherwise.
- rdy[i]=1 for all i.
- wr_conflict=0.
- Reset overrides every simultaneous write/alloc.
- rd_data/rd_rdy during reset reflect the pre-reset array, plus bypass.

Write, per port w with wr_en[w] && wr_pd[w]!=0:
- regs[wr_pd[w]] <= wr_data[w].
- rdy[wr_pd[w]] <= 1.

Write collision:
- Two enabled ports with equal nonzero PD: the highest-index port wins data.
- wr_conflict <= 1 and holds until reset.

Allocate, per port a with alloc_en[a] && alloc_pd[a]!=0:
- rdy[alloc_pd[a]] <= 0.
- Allocate beats write on the same index in the same cycle: ready ends 0, data is still written.

Read, per port r (combinational):
- ps==0 → data 0, rdy 1.
- Any enabled write this cycle with wr_pd==ps → data = winning write's data, rdy 1 (bypass).
- Otherwise regs[ps], rdy[ps].
- A same-cycle allocation does not affect the read outputs; it takes effect after the edge.

Other rules:
- No arithmetic; indices are used modulo 2^PW.
- Out-of-range indices cannot occur when NUM_PREGS==2^PW.

## Timing
- Read latency 0: rd_data/rd_rdy are combinational from rd_ps, the array, and the current-cycle write ports.
- A write is bypass-visible in its own cycle and array-visible from the next cycle.
- An allocation clear is visible at rd_rdy from the cycle after alloc_en.
- wr_conflict asserts the cycle after the colliding writes.
- No handshakes: every enabled write/alloc is accepted unconditionally each cycle.
- Reset values:
  - wr_conflict=0.
  - rd_rdy=1 for every port once reset completes.
  - rd_data = identity values for indices <ARCH_REGS, 0 otherwise.

## Test plan
- Reset then read: release reset, read p5 and p40 → rd_data 5 and 0, rd_rdy 1 on both; read p0 → 0, rdy 1.
- Allocate and write back: alloc p40, next cycle read p40 → rdy 0. Write p40=0xDEADBEEF on port 1, same cycle read p40 → 0xDEADBEEF, rdy 1 (bypass). Next cycle, no write → still 0xDEADBEEF, rdy 1.
- Write collision: ports 0 and 1 both write p70, with 0x11 and 0x22 → same-cycle read 0x22; next cycle regs[p70]=0x22 and wr_conflict=1, which stays 1 until reset.
- Alloc and write same index: alloc p90 and write p90=0x55 in the same cycle → next cycle read 0x55, rdy 0.
- p0 protection: write p0=0xFFFF and alloc p0 → read p0 gives 0 with rdy 1, both same cycle and next cycle.
- Reset mid-operation: with p33=0x1234 and rdy[p40]=0, assert reset for one edge while writing p33=0x9 → afterwards p33 reads 0, p40 reads rdy 1, wr_conflict 0.
